// File: rtl/sampler_pkg.sv
// -----------------------------------------------------------------------------
// sampler_pkg
// Shared definitions for the probabilistic-search Sampler path:
//   - segment type encodings (seg_type_e)
//   - default value width for from/to/weight fields
//   - 16-bit LFSR width, tap mask, reset value and single-step function
//   - segment_selector FSM state encoding
// -----------------------------------------------------------------------------
package sampler_pkg;

    localparam int VAL_W  = 8;
    localparam int LFSR_W = 16;

    // Taps for x^16 + x^14 + x^13 + x^11 + 1 on a left-shifting register:
    // bits 15, 13, 12 and 10 feed the XOR that enters at bit 0.
    localparam logic [LFSR_W-1:0] LFSR_TAPS  = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_RESET = 16'h0001;

    typedef enum logic [1:0] {
        SEG_INVALID = 2'd0,
        SEG_EXPDOWN = 2'd1,
        SEG_EXPUP   = 2'd2,
        SEG_UNIFORM = 2'd3
    } seg_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAW,
        ST_SCAN,
        ST_DONE
    } sel_state_e;

    // One Fibonacci step: shift left, feedback parity enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/segment_selector_if.sv
// -----------------------------------------------------------------------------
// segment_selector_if
// Groups the seed, table-write, request and result signals of segment_selector.
//   master : the controller side (drives in_*, observes out_*)
//   slave  : the segment_selector side
// Parameters must match the ones given to segment_selector.
// -----------------------------------------------------------------------------
interface segment_selector_if #(
    parameter int IDX_W  = 3,
    parameter int VAL_W  = 8,
    parameter int PROB_W = 8
);
    // LFSR seeding
    logic              in_seed_load;
    logic [15:0]       in_seed;
    // Table write port
    logic              in_wr_en;
    logic [IDX_W-1:0]  in_wr_index;
    logic [VAL_W-1:0]  in_wr_from;
    logic [VAL_W-1:0]  in_wr_to;
    logic [1:0]        in_wr_type;
    logic [VAL_W-1:0]  in_wr_weight;
    logic [PROB_W-1:0] in_wr_prob;
    // Request
    logic [IDX_W:0]    in_num_segments;
    logic              in_start;
    // Result
    logic              out_busy;
    logic              out_valid;
    logic              out_error;
    logic [IDX_W-1:0]  out_index;
    logic [VAL_W-1:0]  out_from;
    logic [VAL_W-1:0]  out_to;
    logic [1:0]        out_type;
    logic [VAL_W-1:0]  out_weight;

    modport master (
        output in_seed_load, in_seed,
        output in_wr_en, in_wr_index, in_wr_from, in_wr_to, in_wr_type,
        output in_wr_weight, in_wr_prob,
        output in_num_segments, in_start,
        input  out_busy, out_valid, out_error, out_index,
        input  out_from, out_to, out_type, out_weight
    );

    modport slave (
        input  in_seed_load, in_seed,
        input  in_wr_en, in_wr_index, in_wr_from, in_wr_to, in_wr_type,
        input  in_wr_weight, in_wr_prob,
        input  in_num_segments, in_start,
        output out_busy, out_valid, out_error, out_index,
        output out_from, out_to, out_type, out_weight
    );

endinterface

// File: rtl/lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// 16-bit Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1.
// Ports:
//   in_clock   rising-edge clock
//   in_reset   synchronous active-low reset (value -> 16'h0001)
//   in_enable  advance one step this cycle
//   in_load    load in_seed (takes priority over in_enable); seed 0 -> 16'h0001
//   in_seed    seed value
//   out_value  current register value
// -----------------------------------------------------------------------------
module lfsr16
    import sampler_pkg::*;
(
    input  logic              in_clock,
    input  logic              in_reset,
    input  logic              in_enable,
    input  logic              in_load,
    input  logic [LFSR_W-1:0] in_seed,
    output logic [LFSR_W-1:0] out_value
);

    logic [LFSR_W-1:0] value_q;
    logic [LFSR_W-1:0] value_d;

    // An all-zero state would lock the register, so a zero seed is remapped.
    always_comb begin
        value_d = value_q;
        if (in_load) begin
            value_d = (in_seed == '0) ? LFSR_RESET : in_seed;
        end else if (in_enable) begin
            value_d = lfsr_step(value_q);
        end
    end

    always_ff @(posedge in_clock) begin
        if (!in_reset) begin
            value_q <= LFSR_RESET;
        end else begin
            value_q <= value_d;
        end
    end

    assign out_value = value_q;

endmodule

// File: rtl/segment_selector.sv
// -----------------------------------------------------------------------------
// segment_selector
// Holds up to MAX_SEGMENTS segment descriptors (from, to, type, weight, prob)
// and, on request, picks one at random with probability proportional to its
// prob field. The chosen entry is presented with a one-cycle out_valid pulse.
// Ports:
//   in_clock  rising-edge clock
//   in_reset  synchronous active-low reset (table contents are kept)
//   bus_if    slave side of segment_selector_if: seed load, table write,
//             start/num_segments request, busy/valid/error and result fields
// Flow: IDLE -> ACCUM (sum probs, N cycles) -> DRAW (scale LFSR into
// [0,total)) -> SCAN (walk cumulative sum, <= N cycles) -> DONE -> IDLE.
// -----------------------------------------------------------------------------
module segment_selector #(
    parameter int MAX_SEGMENTS = 8,
    parameter int IDX_W        = 3,
    parameter int VAL_W        = sampler_pkg::VAL_W,
    parameter int PROB_W       = 8
) (
    input  logic              in_clock,
    input  logic              in_reset,
    segment_selector_if.slave bus_if
);
    import sampler_pkg::*;

    // N entries of PROB_W bits sum to at most PROB_W+IDX_W+1 bits.
    localparam int TOT_W  = PROB_W + IDX_W + 1;
    localparam int PROD_W = LFSR_W + TOT_W;

    // Segment table (no reset: contents survive in_reset)
    logic [VAL_W-1:0]  from_mem   [MAX_SEGMENTS];
    logic [VAL_W-1:0]  to_mem     [MAX_SEGMENTS];
    logic [1:0]        type_mem   [MAX_SEGMENTS];
    logic [VAL_W-1:0]  weight_mem [MAX_SEGMENTS];
    logic [PROB_W-1:0] prob_mem   [MAX_SEGMENTS];

    // FSM state and datapath registers
    sel_state_e        state_q;
    logic [IDX_W:0]    n_q;
    logic [IDX_W-1:0]  i_q;
    logic [TOT_W-1:0]  total_q;
    logic [TOT_W-1:0]  cum_q;
    logic [TOT_W-1:0]  target_q;

    // Registered outputs
    logic              busy_q;
    logic              valid_q;
    logic              error_q;
    logic [IDX_W-1:0]  index_q;
    logic [VAL_W-1:0]  from_q;
    logic [VAL_W-1:0]  to_q;
    logic [1:0]        type_q;
    logic [VAL_W-1:0]  weight_q;

    // Combinational helpers
    logic              wr_accept;
    logic              seed_load_ok;
    logic              lfsr_advance;
    logic              start_n_ok;
    logic              last_entry;
    logic              hit;
    logic [LFSR_W-1:0] lfsr_value;
    logic [PROB_W-1:0] entry_prob;
    logic [TOT_W-1:0]  total_d;
    logic [TOT_W-1:0]  cum_d;
    logic [TOT_W-1:0]  target_d;
    logic [PROD_W-1:0] product;

    assign wr_accept    = bus_if.in_wr_en && (state_q == ST_IDLE);
    assign seed_load_ok = bus_if.in_seed_load && (state_q == ST_IDLE);
    assign lfsr_advance = (state_q == ST_DRAW);

    assign start_n_ok = (bus_if.in_num_segments != '0) &&
                        (bus_if.in_num_segments <= (IDX_W+1)'(MAX_SEGMENTS));

    assign entry_prob = prob_mem[i_q];
    assign total_d    = total_q + TOT_W'(entry_prob);
    assign cum_d      = cum_q + TOT_W'(entry_prob);
    assign last_entry = ({1'b0, i_q} == (n_q - (IDX_W+1)'(1)));

    // Strict compare: an entry with prob 0 leaves cum unchanged, so it can
    // never be the first index where target < cum.
    assign hit = (target_q < cum_d);

    // (lfsr * total) >> 16 lies in [0, total) because lfsr < 2^16.
    assign product  = PROD_W'(lfsr_value) * PROD_W'(total_q);
    assign target_d = TOT_W'(product >> LFSR_W);

    lfsr16 u_lfsr (
        .in_clock  (in_clock),
        .in_reset  (in_reset),
        .in_enable (lfsr_advance),
        .in_load   (seed_load_ok),
        .in_seed   (bus_if.in_seed),
        .out_value (lfsr_value)
    );

    // Table write port
    always_ff @(posedge in_clock) begin
        if (wr_accept) begin
            from_mem[bus_if.in_wr_index]   <= bus_if.in_wr_from;
            to_mem[bus_if.in_wr_index]     <= bus_if.in_wr_to;
            type_mem[bus_if.in_wr_index]   <= bus_if.in_wr_type;
            weight_mem[bus_if.in_wr_index] <= bus_if.in_wr_weight;
            prob_mem[bus_if.in_wr_index]   <= bus_if.in_wr_prob;
        end
    end

    // Selection FSM with registered outputs
    always_ff @(posedge in_clock) begin
        if (!in_reset) begin
            state_q  <= ST_IDLE;
            n_q      <= '0;
            i_q      <= '0;
            total_q  <= '0;
            cum_q    <= '0;
            target_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            index_q  <= '0;
            from_q   <= '0;
            to_q     <= '0;
            type_q   <= SEG_INVALID;
            weight_q <= '0;
        end else begin
            valid_q <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus_if.in_start) begin
                        if (start_n_ok) begin
                            n_q     <= bus_if.in_num_segments;
                            i_q     <= '0;
                            total_q <= '0;
                            busy_q  <= 1'b1;
                            state_q <= ST_ACCUM;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                ST_ACCUM: begin
                    total_q <= total_d;
                    i_q     <= i_q + IDX_W'(1);
                    if (last_entry) begin
                        if (total_d == '0) begin
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_DRAW;
                        end
                    end
                end
                ST_DRAW: begin
                    target_q <= target_d;
                    cum_q    <= '0;
                    i_q      <= '0;
                    state_q  <= ST_SCAN;
                end
                ST_SCAN: begin
                    cum_q <= cum_d;
                    i_q   <= i_q + IDX_W'(1);
                    if (hit) begin
                        index_q  <= i_q;
                        from_q   <= from_mem[i_q];
                        to_q     <= to_mem[i_q];
                        type_q   <= type_mem[i_q];
                        weight_q <= weight_mem[i_q];
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= ST_DONE;
                    end else if (last_entry) begin
                        // Unreachable while target < total; kept so a
                        // corrupted target can never wedge the FSM.
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_if.out_busy   = busy_q;
    assign bus_if.out_valid  = valid_q;
    assign bus_if.out_error  = error_q;
    assign bus_if.out_index  = index_q;
    assign bus_if.out_from   = from_q;
    assign bus_if.out_to     = to_q;
    assign bus_if.out_type   = type_q;
    assign bus_if.out_weight = weight_q;

endmodule

// File: tb/tb_segment_selector.sv
// -----------------------------------------------------------------------------
// tb_segment_selector
// Directed, table-driven bench for segment_selector. Expected values come from
// hand-computed vectors, a shadow copy of the table and a small LFSR model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_segment_selector;

    localparam int IDX_W  = 3;
    localparam int VAL_W  = 8;
    localparam int PROB_W = 8;
    localparam int MAXS   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    segment_selector_if #(.IDX_W(IDX_W), .VAL_W(VAL_W), .PROB_W(PROB_W)) bus_if ();

    segment_selector #(
        .MAX_SEGMENTS (MAXS),
        .IDX_W        (IDX_W),
        .VAL_W        (VAL_W),
        .PROB_W       (PROB_W)
    ) dut (
        .in_clock (clk),
        .in_reset (rst_n),
        .bus_if   (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // Shadow of what the table should hold
    logic [7:0] sh_from [MAXS];
    logic [7:0] sh_to   [MAXS];
    logic [1:0] sh_ty   [MAXS];
    logic [7:0] sh_wt   [MAXS];
    int         sh_prob [MAXS];

    typedef struct {
        logic [15:0] seed;
        int          n;
        int          exp_ev;   // 1 = valid, 2 = error
        int          exp_idx;
    } vec_t;
    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference LFSR: taps at bits 15,13,12,10, shift left, feedback into bit 0
    function automatic logic [15:0] m_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic int m_pick(input logic [15:0] s, input int n);
        int total = 0;
        int cum = 0;
        longint target;
        for (int i = 0; i < n; i++) total += sh_prob[i];
        target = (longint'(s) * longint'(total)) >> 16;
        for (int i = 0; i < n; i++) begin
            cum += sh_prob[i];
            if (target < longint'(cum)) return i;
        end
        return -1;
    endfunction

    task automatic write_entry(input int idx, input int fr, input int to, input int ty,
                               input int wt, input int pr);
        bus_if.in_wr_en     = 1'b1;
        bus_if.in_wr_index  = 3'(idx);
        bus_if.in_wr_from   = 8'(fr);
        bus_if.in_wr_to     = 8'(to);
        bus_if.in_wr_type   = 2'(ty);
        bus_if.in_wr_weight = 8'(wt);
        bus_if.in_wr_prob   = 8'(pr);
        @(negedge clk);
        bus_if.in_wr_en     = 1'b0;
        sh_from[idx] = 8'(fr);
        sh_to[idx]   = 8'(to);
        sh_ty[idx]   = 2'(ty);
        sh_wt[idx]   = 8'(wt);
        sh_prob[idx] = pr;
    endtask

    task automatic load_seed(input logic [15:0] s);
        bus_if.in_seed      = s;
        bus_if.in_seed_load = 1'b1;
        @(negedge clk);
        bus_if.in_seed_load = 1'b0;
    endtask

    // Issue one start and wait (bounded) for valid or error.
    // ev: 0 none, 1 valid, 2 error; cyc: negedges from start to the event.
    task automatic run_start(input int n, output int ev, output int cyc);
        ev  = 0;
        cyc = 0;
        bus_if.in_num_segments = 4'(n);
        bus_if.in_start        = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus_if.in_start = 1'b0;
            if (bus_if.out_valid) begin ev = 1; cyc = c; break; end
            if (bus_if.out_error) begin ev = 2; cyc = c; break; end
        end
        if (ev == 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: n=%0d no valid or error within 40 cycles, required one", n);
        end else begin
            @(negedge clk);
            check("pulse_one_cycle", {30'd0, bus_if.out_valid, bus_if.out_error}, 32'd0);
        end
    endtask

    // Start a draw and compare the chosen entry against the shadow table.
    task automatic check_sel(input string tag, input int n, input int exp_idx);
        int ev, cyc;
        run_start(n, ev, cyc);
        check({tag, "_valid"}, ev, 1);
        check({tag, "_index"}, bus_if.out_index, exp_idx);
        check({tag, "_from"}, bus_if.out_from, sh_from[exp_idx]);
        check({tag, "_to"}, bus_if.out_to, sh_to[exp_idx]);
        check({tag, "_type"}, bus_if.out_type, sh_ty[exp_idx]);
        check({tag, "_weight"}, bus_if.out_weight, sh_wt[exp_idx]);
        check({tag, "_latency"}, 32'(cyc >= n + 3 && cyc <= 2 * n + 3), 1);
        $display("%s: n=%0d idx=%0d (exp %0d) latency=%0d", tag, n, bus_if.out_index, exp_idx, cyc);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ev, cyc, exp_i, cnt1, mism;
        logic [15:0] mstate;
        bit saw_valid;

        bus_if.in_seed_load    = 1'b0;
        bus_if.in_seed         = '0;
        bus_if.in_wr_en        = 1'b0;
        bus_if.in_wr_index     = '0;
        bus_if.in_wr_from      = '0;
        bus_if.in_wr_to        = '0;
        bus_if.in_wr_type      = '0;
        bus_if.in_wr_weight    = '0;
        bus_if.in_wr_prob      = '0;
        bus_if.in_num_segments = '0;
        bus_if.in_start        = 1'b0;

        // Vector table over probs {4,0,8,4,0,0,0,2}: target = (seed*total)>>16
        vecs[0]  = '{16'h0001, 4, 1, 0};
        vecs[1]  = '{16'h3FFF, 4, 1, 0};   // target 3 < 4
        vecs[2]  = '{16'h4000, 4, 1, 2};   // target 4 skips prob-0 entry 1
        vecs[3]  = '{16'hBFFF, 4, 1, 2};   // target 11 < 12
        vecs[4]  = '{16'hC000, 4, 1, 3};   // target 12
        vecs[5]  = '{16'hFFFF, 4, 1, 3};   // target 15
        vecs[6]  = '{16'h5555, 3, 1, 0};   // total 12, target 3
        vecs[7]  = '{16'h5556, 3, 1, 2};   // total 12, target 4
        vecs[8]  = '{16'hFFFF, 8, 1, 7};   // total 18, target 17, last entry
        vecs[9]  = '{16'hE38E, 8, 1, 3};   // target 15
        vecs[10] = '{16'hE38F, 8, 1, 7};   // target 16 skips entries 4..6
        vecs[11] = '{16'h1234, 1, 1, 0};
        vecs[12] = '{16'h1234, 0, 2, 0};
        vecs[13] = '{16'h1234, 9, 2, 0};
        vecs[14] = '{16'h0000, 4, 1, 0};   // zero seed acts as 1

        // ---- Reset state ----
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",   bus_if.out_busy,   0);
        check("rst_valid",  bus_if.out_valid,  0);
        check("rst_error",  bus_if.out_error,  0);
        check("rst_index",  bus_if.out_index,  0);
        check("rst_from",   bus_if.out_from,   0);
        check("rst_to",     bus_if.out_to,     0);
        check("rst_type",   bus_if.out_type,   0);
        check("rst_weight", bus_if.out_weight, 0);
        check("rst_lfsr",   dut.u_lfsr.out_value, 16'h0001);
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: outputs checked");

        // ---- Single nonzero entry ----
        write_entry(0, 0, 0, 1, 0, 0);
        write_entry(1, -10, 20, 3, 7, 5);
        write_entry(2, 0, 0, 1, 0, 0);
        check_sel("basic", 3, 1);
        check("basic_from_lit", bus_if.out_from, 8'hF6);
        check("basic_to_lit",   bus_if.out_to,   8'd20);

        // ---- Rejected counts ----
        run_start(0, ev, cyc);
        check("n0_error", ev, 2);
        check("n0_error_next_cycle", cyc, 1);
        check("n0_busy", bus_if.out_busy, 0);
        $display("n=0: event=%0d at cycle %0d", ev, cyc);
        run_start(9, ev, cyc);
        check("n9_error", ev, 2);
        $display("n=9: event=%0d at cycle %0d", ev, cyc);

        // ---- All-zero probabilities ----
        for (int i = 0; i < 4; i++) write_entry(i, sh_from[i], sh_to[i], sh_ty[i], sh_wt[i], 0);
        run_start(4, ev, cyc);
        check("zero_error", ev, 2);
        check("zero_after_accum", 32'(cyc > 4), 1);
        check("zero_keep_index", bus_if.out_index, 1);
        check("zero_keep_from", bus_if.out_from, 8'hF6);
        check("zero_keep_to", bus_if.out_to, 8'd20);
        check("zero_keep_type", bus_if.out_type, 3);
        check("zero_keep_weight", bus_if.out_weight, 7);
        $display("zero total: event=%0d at cycle %0d", ev, cyc);

        // ---- Table-driven vectors ----
        begin
            int fr[8] = '{-60, -44, -28, -12, 4, 20, 36, 52};
            int to[8] = '{-50, -30, -10, 10, 30, 50, 70, 90};
            int ty[8] = '{1, 2, 3, 1, 2, 3, 1, 3};
            int wt[8] = '{-4, -3, -2, -1, 1, 2, 3, 4};
            int pr[8] = '{4, 0, 8, 4, 0, 0, 0, 2};
            for (int i = 0; i < MAXS; i++) write_entry(i, fr[i], to[i], ty[i], wt[i], pr[i]);
        end
        for (int v = 0; v < 15; v++) begin
            load_seed(vecs[v].seed);
            if (vecs[v].exp_ev == 1) begin
                check_sel($sformatf("vec%0d", v), vecs[v].n, vecs[v].exp_idx);
            end else begin
                run_start(vecs[v].n, ev, cyc);
                check($sformatf("vec%0d_error", v), ev, 2);
                $display("vec%0d: n=%0d event=%0d", v, vecs[v].n, ev);
            end
        end

        // ---- Write during SCAN is ignored ----
        load_seed(16'hFFFF);
        bus_if.in_num_segments = 4'd4;
        bus_if.in_start = 1'b1;
        ev = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus_if.in_start = 1'b0;
            bus_if.in_wr_en = 1'b0;
            if (c == 6) begin
                check("scan_busy", bus_if.out_busy, 1);
                bus_if.in_wr_index  = 3'd1;
                bus_if.in_wr_from   = sh_from[1];
                bus_if.in_wr_to     = sh_to[1];
                bus_if.in_wr_type   = sh_ty[1];
                bus_if.in_wr_weight = sh_wt[1];
                bus_if.in_wr_prob   = 8'd9;
                bus_if.in_wr_en     = 1'b1;
            end
            if (bus_if.out_valid) begin ev = 1; break; end
        end
        bus_if.in_wr_en = 1'b0;
        check("scanwr_valid", ev, 1);
        check("scanwr_index", bus_if.out_index, 3);
        $display("scan write: draw idx=%0d", bus_if.out_index);
        @(negedge clk);
        load_seed(16'h4000);   // old probs -> idx 2; prob1=9 would give idx 1
        check_sel("readback", 4, 2);

        // ---- Reset during SCAN ----
        load_seed(16'hFFFF);
        bus_if.in_num_segments = 4'd4;
        bus_if.in_start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            bus_if.in_start = 1'b0;
            if (c == 7) rst_n = 1'b0;
        end
        check("midrst_busy",   bus_if.out_busy,   0);
        check("midrst_valid",  bus_if.out_valid,  0);
        check("midrst_index",  bus_if.out_index,  0);
        check("midrst_from",   bus_if.out_from,   0);
        check("midrst_to",     bus_if.out_to,     0);
        check("midrst_type",   bus_if.out_type,   0);
        check("midrst_weight", bus_if.out_weight, 0);
        check("midrst_lfsr",   dut.u_lfsr.out_value, 16'h0001);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus_if.out_valid || bus_if.out_busy) saw_valid = 1'b1;
        end
        check("midrst_no_valid", saw_valid, 0);
        $display("mid-scan reset: outputs cleared, no late valid");
        check_sel("after_reset", 4, 0);

        // ---- Zero seed behaves as 16'h0001 ----
        load_seed(16'h0000);
        check("seed0_lfsr", dut.u_lfsr.out_value, 16'h0001);
        mstate = 16'h0001;
        for (int k = 0; k < 16; k++) begin
            exp_i  = m_pick(mstate, 4);
            mstate = m_next(mstate);
            run_start(4, ev, cyc);
            check("seed0_valid", ev, 1);
            check("seed0_index", bus_if.out_index, exp_i);
            $display("seed0 draw %0d: idx=%0d exp=%0d", k, bus_if.out_index, exp_i);
        end

        // ---- Distribution with probs {1,3} ----
        write_entry(0, sh_from[0], sh_to[0], sh_ty[0], sh_wt[0], 1);
        write_entry(1, sh_from[1], sh_to[1], sh_ty[1], sh_wt[1], 3);
        load_seed(16'hACE1);
        mstate = 16'hACE1;
        cnt1 = 0;
        mism = 0;
        for (int k = 0; k < 4000; k++) begin
            exp_i  = m_pick(mstate, 2);
            mstate = m_next(mstate);
            run_start(2, ev, cyc);
            check("stat_valid", ev, 1);
            check("stat_index", bus_if.out_index, exp_i);
            if (bus_if.out_index !== 3'(exp_i)) mism++;
            if (bus_if.out_index == 3'd1) cnt1++;
            $display("stat draw %0d: idx=%0d exp=%0d", k, bus_if.out_index, exp_i);
        end
        check("stat_share_75pct", 32'(cnt1 >= 2880 && cnt1 <= 3120), 1);
        $display("stat: index1 count=%0d of 4000, model disagreements=%0d", cnt1, mism);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
